// File: rtl/gray_sobel_edge.sv
// Streaming 3x3 Sobel edge detector: raster-scans a grayscale BRAM and writes |Gx|+|Gy| of interior pixels.
// Define SOBEL_BIN_EN to binarize the output against THRESHOLD (255 / 0).
module gray_sobel_edge #(
    parameter int unsigned IMG_WIDTH  = 220,
    parameter int unsigned IMG_HEIGHT = 220,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned THRESHOLD  = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [7:0]            rd_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy,
    output logic                  finish
);

    localparam int unsigned NUM_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned COL_W   = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W   = $clog2(IMG_HEIGHT);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIX - 1);
    localparam logic [ADDR_WIDTH-1:0] CTR_OFS   = ADDR_WIDTH'(IMG_WIDTH + 1);
    localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMG_WIDTH - 1);
    localparam logic [7:0]            THR       = 8'((THRESHOLD > 255) ? 255 : THRESHOLD);

`ifdef SOBEL_BIN_EN
    localparam bit BIN_EN = 1'b1;
`else
    localparam bit BIN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    logic                  rd_vld;
    logic                  win_vld;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      col;
    logic [ADDR_WIDTH-1:0] pix_idx;
    logic [ADDR_WIDTH-1:0] win_addr;

    logic [7:0] lb1 [IMG_WIDTH];
    logic [7:0] lb2 [IMG_WIDTH];
    logic [7:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;

    logic [9:0]         gx_pos_c, gx_neg_c, gy_pos_c, gy_neg_c;
    logic signed [10:0] gx_c, gy_c;
    logic [10:0]        gx_abs_c, gy_abs_c;
    logic [11:0]        mag_c;
    logic [7:0]         sat_c;
    logic [7:0]         pix_out_c;

    // Pass sequencing: address generation, busy and finish
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            rd_addr <= '0;
            busy    <= 1'b0;
            finish  <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SCAN;
                        busy    <= 1'b1;
                        rd_addr <= '0;
                    end
                end
                SCAN: begin
                    if (rd_addr == LAST_ADDR) begin
                        state   <= DRAIN;
                        rd_addr <= '0;
                    end else begin
                        rd_addr <= rd_addr + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (!rd_vld && !win_vld) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        finish <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Track each returning pixel and push window results to the edge BRAM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_vld   <= 1'b0;
            win_vld  <= 1'b0;
            row      <= '0;
            col      <= '0;
            pix_idx  <= '0;
            win_addr <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            rd_vld  <= (state == SCAN);
            win_vld <= 1'b0;
            if (state == IDLE && start) begin
                row     <= '0;
                col     <= '0;
                pix_idx <= '0;
            end else if (rd_vld) begin
                // Window centre sits one row up and one column left of the new pixel
                win_vld  <= (row >= ROW_W'(2)) && (col >= COL_W'(2));
                win_addr <= pix_idx - CTR_OFS;
                pix_idx  <= pix_idx + ADDR_WIDTH'(1);
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
            wr_en <= win_vld;
            if (win_vld) begin
                wr_addr <= win_addr;
                wr_data <= pix_out_c;
            end
        end
    end

    // Line buffers and 3x3 window; contents are fully rewritten before any window is used
    always_ff @(posedge clk) begin
        if (rd_vld) begin
            lb1[col] <= rd_data;
            lb2[col] <= lb1[col];
            p00 <= p01;  p01 <= p02;  p02 <= lb2[col];
            p10 <= p11;  p11 <= p12;  p12 <= lb1[col];
            p20 <= p21;  p21 <= p22;  p22 <= rd_data;
        end
    end

    // Sobel kernels, magnitude and saturation
    always_comb begin
        gx_pos_c  = {2'b00, p02} + {1'b0, p12, 1'b0} + {2'b00, p22};
        gx_neg_c  = {2'b00, p00} + {1'b0, p10, 1'b0} + {2'b00, p20};
        gy_pos_c  = {2'b00, p20} + {1'b0, p21, 1'b0} + {2'b00, p22};
        gy_neg_c  = {2'b00, p00} + {1'b0, p01, 1'b0} + {2'b00, p02};
        gx_c      = $signed({1'b0, gx_pos_c}) - $signed({1'b0, gx_neg_c});
        gy_c      = $signed({1'b0, gy_pos_c}) - $signed({1'b0, gy_neg_c});
        gx_abs_c  = gx_c[10] ? $unsigned(-gx_c) : $unsigned(gx_c);
        gy_abs_c  = gy_c[10] ? $unsigned(-gy_c) : $unsigned(gy_c);
        mag_c     = {1'b0, gx_abs_c} + {1'b0, gy_abs_c};
        sat_c     = (mag_c > 12'd255) ? 8'hFF : mag_c[7:0];
        pix_out_c = sat_c;
        if (BIN_EN) begin
            pix_out_c = (sat_c >= THR) ? 8'hFF : 8'h00;
        end
    end

endmodule

// File: tb/tb_gray_sobel_edge.sv
// Directed bench for gray_sobel_edge on an 8x6 image with a 1-cycle registered BRAM model.
module tb_gray_sobel_edge;

    localparam int unsigned W   = 8;
    localparam int unsigned H   = 6;
    localparam int unsigned AW  = 16;
    localparam int unsigned THR = 10;
    localparam int unsigned N   = W * H;

`ifdef SOBEL_BIN_EN
    localparam bit BIN = 1'b1;
`else
    localparam bit BIN = 1'b0;
`endif

    localparam int PAT_UNIFORM = 0;
    localparam int PAT_STEP    = 1;
    localparam int PAT_RAMP    = 2;

    logic          clk   = 1'b0;
    logic          rstn  = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          finish;

    logic [7:0] mem [64];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int            cap_n;
    int            fin_cyc;
    int            first_cyc;
    int            last_cyc;
    logic [AW-1:0] cap_addr [64];
    logic [7:0]    cap_data [64];
    logic          busy_c1;
    logic          busy_fin;
    logic [AW-1:0] rd_c1;
    logic [AW-1:0] rd_c2;

    always #5 clk = ~clk;

    always_ff @(posedge clk) rd_data <= mem[rd_addr[5:0]];

    gray_sobel_edge #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .ADDR_WIDTH(AW),
        .THRESHOLD (THR)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy   (busy),
        .finish (finish)
    );

    function automatic logic [7:0] pix(input int pat, input int c);
        case (pat)
            PAT_UNIFORM: return 8'd100;
            PAT_STEP:    return (c < 4) ? 8'd0 : 8'd255;
            default:     return 8'(c);
        endcase
    endfunction

    // Hand-derived expected output per centre column for each test image
    function automatic logic [7:0] exp_data(input int pat, input int c);
        case (pat)
            PAT_UNIFORM: return 8'd0;
            PAT_STEP:    return (c == 3 || c == 4) ? 8'd255 : 8'd0;
            default:     return BIN ? 8'd0 : 8'd8;
        endcase
    endfunction

    task automatic load_image(input int pat);
        for (int i = 0; i < 64; i++) begin
            mem[i] = (i < int'(N)) ? pix(pat, i % int'(W)) : 8'd0;
        end
    endtask

    // Launch one pass and record every write and the finish cycle (cycle 1 follows the start edge)
    task automatic run_pass();
        cap_n     = 0;
        fin_cyc   = -1;
        first_cyc = -1;
        last_cyc  = -1;
        busy_fin  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            if (j == 1) begin
                busy_c1 = busy;
                rd_c1   = rd_addr;
            end
            if (j == 2) rd_c2 = rd_addr;
            if (wr_en) begin
                if (first_cyc < 0) first_cyc = j;
                last_cyc = j;
                if (cap_n < 64) begin
                    cap_addr[cap_n] = wr_addr;
                    cap_data[cap_n] = wr_data;
                end
                cap_n++;
            end
            if (finish) begin
                fin_cyc  = j;
                busy_fin = busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn  = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", wr_en); end else n_pass++;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end else n_pass++;
        n_checks++; if (finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish got %b want 0", finish); end else n_pass++;
        n_checks++; if (rd_addr !== 16'd0) begin n_fail++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr); end else n_pass++;
        n_checks++; if (wr_addr !== 16'd0) begin n_fail++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end else n_pass++;
        n_checks++; if (wr_data !== 8'd0) begin n_fail++; $display("FAIL reset_wr_data got %0d want 0", wr_data); end else n_pass++;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end else n_pass++;
    endtask

    task automatic test_images();
        for (int p = 0; p < 3; p++) begin
            load_image(p);
            repeat (3) @(negedge clk);
            run_pass();
            n_checks++; if (fin_cyc != 52) begin n_fail++; $display("FAIL img%0d_finish_cycle got %0d want 52", p, fin_cyc); end else n_pass++;
            n_checks++; if (busy_fin !== 1'b0) begin n_fail++; $display("FAIL img%0d_busy_at_finish got %b want 0", p, busy_fin); end else n_pass++;
            n_checks++; if (busy_c1 !== 1'b1) begin n_fail++; $display("FAIL img%0d_busy_cycle1 got %b want 1", p, busy_c1); end else n_pass++;
            n_checks++; if (rd_c1 !== 16'd0) begin n_fail++; $display("FAIL img%0d_rd_addr_cycle1 got %0d want 0", p, rd_c1); end else n_pass++;
            n_checks++; if (rd_c2 !== 16'd1) begin n_fail++; $display("FAIL img%0d_rd_addr_cycle2 got %0d want 1", p, rd_c2); end else n_pass++;
            n_checks++; if (cap_n != 24) begin n_fail++; $display("FAIL img%0d_write_count got %0d want 24", p, cap_n); end else n_pass++;
            n_checks++; if (first_cyc != 22) begin n_fail++; $display("FAIL img%0d_first_write_cycle got %0d want 22", p, first_cyc); end else n_pass++;
            n_checks++; if (last_cyc != 51) begin n_fail++; $display("FAIL img%0d_last_write_cycle got %0d want 51", p, last_cyc); end else n_pass++;
            for (int i = 0; i < 24 && i < cap_n; i++) begin
                int c  = 1 + i % 6;
                int ea = (1 + i / 6) * int'(W) + c;
                n_checks++; if (cap_addr[i] !== 16'(ea)) begin n_fail++; $display("FAIL img%0d_addr[%0d] got %0d want %0d", p, i, cap_addr[i], ea); end else n_pass++;
                n_checks++; if (cap_data[i] !== exp_data(p, c)) begin n_fail++; $display("FAIL img%0d_data[%0d] got %0d want %0d", p, i, cap_data[i], exp_data(p, c)); end else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        logic any_wr;
        logic any_act;
        load_image(PAT_STEP);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (j == 10) start = 1'b1;
            if (j == 11) start = 1'b0;
        end
        n_checks++; if (rd_addr !== 16'd19) begin n_fail++; $display("FAIL midpass_rd_addr got %0d want 19", rd_addr); end else n_pass++;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midpass_busy got %b want 1", busy); end else n_pass++;
        rstn = 1'b0;
        #1;
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL async_rst_wr_en got %b want 0", wr_en); end else n_pass++;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy got %b want 0", busy); end else n_pass++;
        n_checks++; if (finish !== 1'b0) begin n_fail++; $display("FAIL async_rst_finish got %b want 0", finish); end else n_pass++;
        n_checks++; if (rd_addr !== 16'd0) begin n_fail++; $display("FAIL async_rst_rd_addr got %0d want 0", rd_addr); end else n_pass++;
        any_wr  = 1'b0;
        any_act = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            any_wr  = any_wr | wr_en;
            any_act = any_act | finish | busy;
        end
        rstn = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            any_wr  = any_wr | wr_en;
            any_act = any_act | finish | busy;
        end
        n_checks++; if (any_wr !== 1'b0) begin n_fail++; $display("FAIL post_rst_write got %b want 0", any_wr); end else n_pass++;
        n_checks++; if (any_act !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy_or_finish got %b want 0", any_act); end else n_pass++;
        run_pass();
        n_checks++; if (fin_cyc != 52) begin n_fail++; $display("FAIL restart_finish_cycle got %0d want 52", fin_cyc); end else n_pass++;
        n_checks++; if (cap_n != 24) begin n_fail++; $display("FAIL restart_write_count got %0d want 24", cap_n); end else n_pass++;
        for (int i = 0; i < 24 && i < cap_n; i++) begin
            int c  = 1 + i % 6;
            int ea = (1 + i / 6) * int'(W) + c;
            n_checks++; if (cap_addr[i] !== 16'(ea)) begin n_fail++; $display("FAIL restart_addr[%0d] got %0d want %0d", i, cap_addr[i], ea); end else n_pass++;
            n_checks++; if (cap_data[i] !== exp_data(PAT_STEP, c)) begin n_fail++; $display("FAIL restart_data[%0d] got %0d want %0d", i, cap_data[i], exp_data(PAT_STEP, c)); end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int first_n;
        int first_fin;
        load_image(PAT_RAMP);
        repeat (2) @(negedge clk);
        run_pass();
        first_n   = cap_n;
        first_fin = fin_cyc;
        // Start is driven during the cycle right after finish
        @(posedge clk);
        #1;
        run_pass();
        n_checks++; if (first_fin != 52) begin n_fail++; $display("FAIL b2b_first_finish_cycle got %0d want 52", first_fin); end else n_pass++;
        n_checks++; if (first_n != 24) begin n_fail++; $display("FAIL b2b_first_write_count got %0d want 24", first_n); end else n_pass++;
        n_checks++; if (fin_cyc != 52) begin n_fail++; $display("FAIL b2b_second_finish_cycle got %0d want 52", fin_cyc); end else n_pass++;
        n_checks++; if (busy_c1 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_busy_cycle1 got %b want 1", busy_c1); end else n_pass++;
        n_checks++; if (cap_n != 24) begin n_fail++; $display("FAIL b2b_second_write_count got %0d want 24", cap_n); end else n_pass++;
        for (int i = 0; i < 24 && i < cap_n; i++) begin
            int c  = 1 + i % 6;
            int ea = (1 + i / 6) * int'(W) + c;
            n_checks++; if (cap_addr[i] !== 16'(ea)) begin n_fail++; $display("FAIL b2b_addr[%0d] got %0d want %0d", i, cap_addr[i], ea); end else n_pass++;
            n_checks++; if (cap_data[i] !== exp_data(PAT_RAMP, c)) begin n_fail++; $display("FAIL b2b_data[%0d] got %0d want %0d", i, cap_data[i], exp_data(PAT_RAMP, c)); end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_images();
        test_reset_mid_pass();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/gray_sobel_edge.md
# gray_sobel_edge

Streaming 3x3 Sobel edge detector that sits directly downstream of the RGB→grayscale stage. When started, it raster-scans the 8-bit grayscale BRAM one pixel per cycle and forms 3x3 windows with two internal line buffers. It writes the edge magnitude of every interior pixel into a separate 8-bit edge BRAM at the same linear address. Border pixels (row 0, last row, column 0, last column) are never written.

## Interface
- IMG_WIDTH, 220, pixels per row (≥3)
- IMG_HEIGHT, 220, rows per image (≥3)
- ADDR_WIDTH, 16, BRAM address width; IMG_WIDTH*IMG_HEIGHT ≤ 2^ADDR_WIDTH
- THRESHOLD, 64, binarization threshold (used only with SOBEL_BIN_EN)
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin one image pass; sampled only in IDLE
- rd_addr  out  ADDR_WIDTH  grayscale BRAM read address
- rd_data  in  8  grayscale BRAM data; valid exactly 1 cycle after rd_addr is presented (registered BRAM)
- wr_en  out  1  edge BRAM write strobe
- wr_addr  out  ADDR_WIDTH  edge BRAM write address
- wr_data  out  8  edge magnitude
- busy  out  1  pass in progress
- finish  out  1  one-cycle pulse at end of pass

## Operation
- Reset values: rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, finish=0, state=IDLE. Line-buffer contents are not cleared; they are fully rewritten before use.
- FSM states:
  - IDLE: if start=1, go to SCAN and assert busy.
  - SCAN: rd_addr steps 0..N-1, one address per cycle (N=IMG_WIDTH*IMG_HEIGHT). After N-1, go to DRAIN.
  - DRAIN: wait until the pipeline is empty, then go to DONE.
  - DONE: finish=1 and busy=0 for one cycle, then return to IDLE.
- Data pipeline: a row/column counter tracks each returning pixel (r,c). Line buffer 1 holds row r-1 and line buffer 2 holds row r-2, each IMG_WIDTH×8. A 3x3 window shift register is loaded with the new column on each returning pixel. Column wrap resets the window validity.
- A window is valid when r≥2 and c≥2. Its centre is (r-1,c-1), so wr_addr = (r-1)*IMG_WIDTH + (c-1).
- Kernels:
  - Gx = (p02+2p12+p22) − (p00+2p10+p20)
  - Gy = (p20+2p21+p22) − (p00+2p01+p02)
  - Both are signed 11-bit.
- Magnitude: |Gx|+|Gy| in 12 bits unsigned, saturated to 255. The result is registered to wr_data.
- Writes per pass: exactly (IMG_WIDTH−2)*(IMG_HEIGHT−2), in ascending address order.
- start while busy is ignored. start held high continuously relaunches a pass only from IDLE.
- Reset mid-pass: all outputs return to reset values immediately. No further writes occur, no finish is issued, and a new start runs a complete, correct pass.

## Timing
- Edge E0 samples start=1; rd_addr=k is driven during cycle k+1 after E0.
- The write produced by pixel k appears 3 cycles after rd_addr=k: one cycle BRAM latency, one cycle window/Sobel, one cycle magnitude register.
- Last write occurs in cycle N+3. finish is high in cycle N+4 (48404 for 220x220). The first start is accepted in the cycle after finish.
- wr_en is a single-cycle strobe per pixel. wr_addr and wr_data are valid only while wr_en=1.

## Configuration
- SOBEL_BIN_EN defined: wr_data = (saturated magnitude ≥ THRESHOLD) ? 8'd255 : 8'd0. Latency is unchanged.
- SOBEL_BIN_EN undefined: wr_data is the saturated magnitude (0..255) and THRESHOLD is unused.

## Test plan
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=6 and a behavioural 1-cycle BRAM model.
- Uniform image, all pixels 100 → 24 writes, all wr_data=0, addresses 9..14, 17..22, 25..30, 33..38; finish in cycle 52, busy low at the same time.
- Vertical step, columns 0–3 =0 and columns 4–7 =255 → wr_data=255 at columns 3 and 4 of rows 1–4 (raw 1020 saturated); 0 elsewhere.
- Horizontal ramp, pixel = column index → every interior wr_data=8 (Gx=8, Gy=0).
- With SOBEL_BIN_EN, THRESHOLD=10: ramp image → all 0; step image → 255 only at columns 3 and 4.
- rstn asserted 20 cycles into a pass → wr_en, busy and finish are 0 immediately. A pulse of start during the first pass is ignored; a restart after reset reproduces the step-image results exactly.
- start asserted in the cycle after finish → second pass begins immediately and its write sequence is identical to the first.
